merge_n: RTL and testbench
==========================

MERGE_N -- requirements
Module: merge_n

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-002 The block SHALL have parameter NUM_INPUTS, default 4, number of input channels (legal range 2..16).
REQ-003 The block SHALL have parameter ARB_MODE, default 0, arbitration mode (0 = fixed priority, 1 = round-robin).
REQ-004 The block SHALL derive SRC_W = max(1, ceil(log2(NUM_INPUTS))) internally; SRC_W is not user-settable.
REQ-005 clk  input  1  clock; all state updates occur on the falling edge.
REQ-006 rst  input  1  reset; synchronous, active-low.
REQ-007 din  input  NUM_INPUTS*DATA_WIDTH  concatenated input FIFO data; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 buffer_empty  input  NUM_INPUTS  per-channel input FIFO empty flags.
REQ-009 chan_en  input  NUM_INPUTS  per-channel enable mask; 0 excludes the channel from arbitration.
REQ-010 buffer_out_full  input  1  output FIFO full flag.
REQ-011 read_en  output  NUM_INPUTS  per-channel FIFO read strobes, registered.
REQ-012 dout  output  DATA_WIDTH  merged data word, registered.
REQ-013 dout_src  output  SRC_W  index of the channel that supplied dout, registered.
REQ-014 wen  output  1  output FIFO write strobe, registered.

Function
REQ-015 Channel i SHALL be eligible at an edge when buffer_empty[i]=0 and chan_en[i]=1.
REQ-016 The block SHALL issue a read at an edge only if at least one channel is eligible, buffer_out_full=0 and stall=0; otherwise read_en SHALL be all-zero after that edge.
REQ-017 read_en SHALL be one-hot or zero, and each strobe SHALL last exactly one cycle.
REQ-018 ARB_MODE=0 SHALL grant the lowest-index eligible channel.
REQ-019 ARB_MODE=1 SHALL grant the first eligible channel searching upward from last_grant+1 with wrap from NUM_INPUTS-1 to 0; last_grant updates only on a grant.
REQ-020 The environment SHALL guarantee that buffer_empty sampled at an edge already reflects a read strobe issued at the previous edge, so back-to-back reads of one channel are legal.
REQ-021 At the edge following read_en[i]=1, the block SHALL load dout with din slice i and dout_src with i, irrespective of buffer_out_full.
REQ-022 At that capture edge, if buffer_out_full=0 the block SHALL set wen=1; otherwise it SHALL set wen=0 and stall=1.
REQ-023 While stall=1 and buffer_out_full=1, the block SHALL hold dout and dout_src and keep wen=0.
REQ-024 While stall=1 and buffer_out_full=0, the block SHALL set wen=1 and clear stall; no read is issued at that edge.
REQ-025 A new read MAY be issued at the same edge as a non-stalled capture, giving a sustained throughput of one word per cycle.
REQ-026 Latency SHALL be one edge from eligibility to read_en, and one further edge from read_en to wen (two cycles total when idle).
REQ-027 wen SHALL be high for exactly one cycle per word; no word SHALL be dropped or duplicated.
REQ-028 Deasserting chan_en or asserting buffer_empty after a read is issued SHALL NOT cancel the capture of that read.
REQ-029 When wen=0, dout and dout_src SHALL retain their last values.

Reset
REQ-030 When rst=0 at a falling edge, the block SHALL set read_en=0, wen=0, dout=0, dout_src=0, stall=0, the pending-capture flag to 0, and last_grant=NUM_INPUTS-1.
REQ-031 Reset asserted mid-operation SHALL discard any pending or stalled word; no wen SHALL follow.
REQ-032 rst SHALL take precedence over all other inputs.

Verification
REQ-033 Reset: with rst=0 for 2 edges while all channels are non-empty -> read_en=0, wen=0, dout=0 throughout.
REQ-034 Fixed priority (NUM_INPUTS=4, ARB_MODE=0): channels 1 and 3 each hold 3 words -> words from channel 1 (dout_src=1) appear first, then channel 3, with wen high on 6 consecutive cycles.
REQ-035 Round-robin (ARB_MODE=1): all 4 channels hold 2 words -> dout_src sequence is 0,1,2,3,0,1,2,3.
REQ-036 Backpressure: buffer_out_full=1 rises on the capture edge of word 0xA5A5A5A5 -> wen=0 and dout held for 3 cycles; after full falls, wen=1 for one cycle with the same dout and no loss or duplication.
REQ-037 Mask: channel 0 is non-empty with chan_en[0]=0 -> no read_en[0]; after setting chan_en[0]=1 -> read_en[0] is asserted at the next edge.
REQ-038 Mid-operation reset: rst=0 on the edge after read_en[2]=1 -> no wen and dout=0.

Source files
------------

// File: rtl/merge_n_if.sv
`default_nettype none
// ============================================================================
//  Module   : merge_n_if
//  Brief    : Bundle of N-input merge FIFO-side signals (inputs, strobes, output word).
//  Revision : 1.0
// ============================================================================
interface merge_n_if #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_INPUTS = 4
);
   localparam int SRC_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

   logic [NUM_INPUTS*DATA_WIDTH-1:0] din;
   logic [NUM_INPUTS-1:0]            buffer_empty;
   logic [NUM_INPUTS-1:0]            chan_en;
   logic                             buffer_out_full;
   logic [NUM_INPUTS-1:0]            read_en;
   logic [DATA_WIDTH-1:0]            dout;
   logic [SRC_W-1:0]                 dout_src;
   logic                             wen;

   modport master (
      output din, buffer_empty, chan_en, buffer_out_full,
      input  read_en, dout, dout_src, wen
   );

   modport slave (
      input  din, buffer_empty, chan_en, buffer_out_full,
      output read_en, dout, dout_src, wen
   );
endinterface
`default_nettype wire

// File: rtl/merge_n.sv
`default_nettype none
// ============================================================================
//  Module   : merge_n
//  Brief    : Merges N input FIFOs into one output FIFO, fixed or round-robin.
//  Revision : 1.0
// ============================================================================
module merge_n #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_INPUTS = 4,
   parameter int ARB_MODE   = 0
) (
   input  wire logic clk,
   input  wire logic rst,
   merge_n_if.slave  bus
);
   localparam int SRC_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
   localparam logic [SRC_W:0]   c_num_inputs = (SRC_W+1)'(NUM_INPUTS);
   localparam logic [SRC_W-1:0] c_last_init  = SRC_W'(NUM_INPUTS - 1);

   logic [NUM_INPUTS-1:0] r_read_en;
   logic [DATA_WIDTH-1:0] r_dout;
   logic [SRC_W-1:0]      r_dout_src;
   logic                  r_wen;
   logic                  r_stall;
   logic                  r_pending;
   logic [SRC_W-1:0]      r_pend_idx;
   logic [SRC_W-1:0]      r_last_grant;

   logic [NUM_INPUTS-1:0] w_eligible;
   logic                  w_grant_vld;
   logic [SRC_W-1:0]      w_grant_idx;
   logic [SRC_W:0]        w_cand;
   logic                  w_can_read;
   logic [DATA_WIDTH-1:0] w_din_arr [NUM_INPUTS];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_slice
         assign w_din_arr[gi] = bus.din[gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   assign w_eligible = ~bus.buffer_empty & bus.chan_en;

   // Candidate order: 0..N-1 for fixed priority, last_grant+1 upward with wrap otherwise.
   always_comb begin
      w_grant_vld = 1'b0;
      w_grant_idx = '0;
      w_cand      = '0;
      for (int k = 0; k < NUM_INPUTS; k++) begin
         if (ARB_MODE == 0) begin
            w_cand = (SRC_W+1)'(k);
         end else begin
            w_cand = {1'b0, r_last_grant} + (SRC_W+1)'(k + 1);
            if (w_cand >= c_num_inputs) begin
               w_cand = w_cand - c_num_inputs;
            end
         end
         if (!w_grant_vld && w_eligible[w_cand[SRC_W-1:0]]) begin
            w_grant_vld = 1'b1;
            w_grant_idx = w_cand[SRC_W-1:0];
         end
      end
   end

   assign w_can_read = w_grant_vld & ~bus.buffer_out_full & ~r_stall;

   // A capture never coincides with a stall: reads are blocked while full or stalled.
   always_ff @(negedge clk) begin
      if (!rst) begin
         r_read_en    <= '0;
         r_dout       <= '0;
         r_dout_src   <= '0;
         r_wen        <= 1'b0;
         r_stall      <= 1'b0;
         r_pending    <= 1'b0;
         r_pend_idx   <= '0;
         r_last_grant <= c_last_init;
      end else begin
         r_read_en <= '0;
         r_wen     <= 1'b0;
         if (r_pending) begin
            r_dout     <= w_din_arr[r_pend_idx];
            r_dout_src <= r_pend_idx;
            if (!bus.buffer_out_full) begin
               r_wen <= 1'b1;
            end else begin
               r_stall <= 1'b1;
            end
         end else if (r_stall && !bus.buffer_out_full) begin
            r_wen   <= 1'b1;
            r_stall <= 1'b0;
         end
         r_pending <= w_can_read;
         if (w_can_read) begin
            r_read_en    <= NUM_INPUTS'(1) << w_grant_idx;
            r_pend_idx   <= w_grant_idx;
            r_last_grant <= w_grant_idx;
         end
      end
   end

   assign bus.read_en  = r_read_en;
   assign bus.dout     = r_dout;
   assign bus.dout_src = r_dout_src;
   assign bus.wen      = r_wen;
endmodule
`default_nettype wire

// File: tb/tb_merge_n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_merge_n
//  Brief    : Scoreboard bench for merge_n, fixed-priority and round-robin instances.
//  Revision : 1.0
// ============================================================================
module tb_merge_n;
   localparam int DW = 32;
   localparam int N  = 4;
   localparam int SW = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   merge_n_if #(.DATA_WIDTH(DW), .NUM_INPUTS(N)) bus_fp ();
   merge_n_if #(.DATA_WIDTH(DW), .NUM_INPUTS(N)) bus_rr ();

   merge_n #(.DATA_WIDTH(DW), .NUM_INPUTS(N), .ARB_MODE(0)) dut_fp (
      .clk (clk),
      .rst (rst),
      .bus (bus_fp.slave)
   );
   merge_n #(.DATA_WIDTH(DW), .NUM_INPUTS(N), .ARB_MODE(1)) dut_rr (
      .clk (clk),
      .rst (rst),
      .bus (bus_rr.slave)
   );

   // Input FIFO models: read strobe pops into a registered data output.
   logic [DW-1:0]   mem [N][16];
   int              hd [N];
   int              tl [N];
   logic [DW-1:0]   din_r [N];
   logic [N-1:0]    empty;
   logic [N-1:0]    empty_drv;
   logic [N*DW-1:0] din_bus;
   logic [N-1:0]    chen;
   logic            full;
   logic            ovr;
   logic            sel;
   logic            env_on;

   logic [DW-1:0]   exp_d [$];
   int              exp_s [$];
   int              n_vec;
   int              n_err;
   int              n_wen;

   logic [N-1:0]    rd_m;
   logic            wen_m;
   logic [DW-1:0]   dout_m;
   logic [SW-1:0]   src_m;

   initial begin
      for (int i = 0; i < N; i++) begin
         hd[i]    = 0;
         tl[i]    = 0;
         din_r[i] = '0;
      end
   end

   always_comb begin
      for (int i = 0; i < N; i++) begin
         empty[i]              = (hd[i] == tl[i]);
         din_bus[i*DW +: DW]   = din_r[i];
      end
   end
   assign empty_drv = ovr ? '0 : empty;

   assign bus_fp.din             = din_bus;
   assign bus_fp.buffer_empty    = empty_drv;
   assign bus_fp.chan_en         = chen;
   assign bus_fp.buffer_out_full = full;
   assign bus_rr.din             = din_bus;
   assign bus_rr.buffer_empty    = empty_drv;
   assign bus_rr.chan_en         = chen;
   assign bus_rr.buffer_out_full = full;

   assign rd_m   = sel ? bus_rr.read_en  : bus_fp.read_en;
   assign wen_m  = sel ? bus_rr.wen      : bus_fp.wen;
   assign dout_m = sel ? bus_rr.dout     : bus_fp.dout;
   assign src_m  = sel ? bus_rr.dout_src : bus_fp.dout_src;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic load(input int ch, input logic [DW-1:0] w, input bit push);
      mem[ch][tl[ch]] = w;
      tl[ch]++;
      if (push) begin
         exp_d.push_back(w);
         exp_s.push_back(ch);
      end
   endtask

   task automatic wait_rd(input logic [N-1:0] m, input int budget, input string tag);
      int k = 0;
      do begin
         @(posedge clk);
         k++;
      end while (rd_m !== m && k < budget);
      check(tag, 64'(rd_m), 64'(m));
   endtask

   task automatic wait_drain(input int budget, input string tag);
      int k = 0;
      while (exp_d.size() != 0 && k < budget) begin
         @(posedge clk);
         k++;
      end
      repeat (3) @(posedge clk);
      check(tag, 64'(exp_d.size()), 64'd0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
   endtask

   // Environment side, sampled opposite the DUT's falling active edge.
   always @(posedge clk) begin
      if (env_on) begin
         check("rd_onehot", 64'($onehot0(rd_m)), 64'd1);
         for (int i = 0; i < N; i++) begin
            if (rd_m[i]) begin
               if (hd[i] != tl[i]) begin
                  din_r[i] = mem[i][hd[i]];
                  hd[i]++;
               end else begin
                  check("fifo_underflow", 64'd1, 64'd0);
               end
            end
         end
         if (wen_m) begin
            n_wen++;
            if (exp_d.size() == 0) begin
               check("unexpected_wen", 64'd1, 64'd0);
            end else begin
               check("dout", 64'(dout_m), 64'(exp_d.pop_front()));
               check("dout_src", 64'(src_m), 64'(exp_s.pop_front()));
            end
         end
      end
   end

   initial begin
      int lat;
      int base;
      n_vec  = 0;
      n_err  = 0;
      n_wen  = 0;
      sel    = 1'b0;
      full   = 1'b0;
      chen   = '1;
      ovr    = 1'b1;
      env_on = 1'b0;
      rst    = 1'b0;

      // Reset held while every channel looks non-empty.
      @(negedge clk);
      env_on = 1'b1;
      repeat (2) begin
         @(posedge clk);
         check("rst_read_en", 64'(bus_fp.read_en | bus_rr.read_en), 64'd0);
         check("rst_wen", 64'(bus_fp.wen | bus_rr.wen), 64'd0);
         check("rst_dout", 64'(bus_fp.dout | bus_rr.dout), 64'd0);
      end
      #1 ovr = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;

      // Fixed priority: channel 1 drains before channel 3, six back-to-back writes.
      sel = 1'b0;
      @(posedge clk);
      #1;
      for (int w = 0; w < 3; w++) load(1, 32'h1100_0000 + 32'(w), 1'b1);
      for (int w = 0; w < 3; w++) load(3, 32'h3300_0000 + 32'(w), 1'b1);
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
      end while (!wen_m && lat < 10);
      check("fp_latency", 64'(lat), 64'd2);
      repeat (5) begin
         @(posedge clk);
         check("fp_burst_wen", 64'(wen_m), 64'd1);
      end
      @(posedge clk);
      check("fp_burst_end", 64'(wen_m), 64'd0);
      wait_drain(20, "fp_drain");

      // Round-robin: two words per channel come out 0,1,2,3,0,1,2,3.
      do_reset();
      sel  = 1'b1;
      base = n_wen;
      @(posedge clk);
      #1;
      for (int w = 0; w < 2; w++)
         for (int c = 0; c < N; c++)
            load(c, 32'h1000_0000 | 32'(c << 8) | 32'(w), 1'b1);
      wait_drain(40, "rr_drain");
      check("rr_wen_count", 64'(n_wen - base), 64'd8);

      // Backpressure: full rises on the capture edge, then a second word queues.
      sel  = 1'b0;
      base = n_wen;
      @(posedge clk);
      #1 load(2, 32'hA5A5_A5A5, 1'b1);
      wait_rd(4'b0100, 10, "bp_read");
      #1 full = 1'b1;
      load(1, 32'hB1B1_B1B1, 1'b1);
      repeat (3) begin
         @(posedge clk);
         check("bp_hold_wen", 64'(wen_m), 64'd0);
         check("bp_hold_dout", 64'(dout_m), 64'hA5A5_A5A5);
      end
      #1 full = 1'b0;
      @(posedge clk);
      check("bp_release_wen", 64'(wen_m), 64'd1);
      check("bp_release_noread", 64'(rd_m), 64'd0);
      @(posedge clk);
      check("bp_single_wen", 64'(wen_m), 64'd0);
      wait_drain(20, "bp_drain");
      check("bp_wen_count", 64'(n_wen - base), 64'd2);

      // Mask: a disabled non-empty channel is never read until enabled.
      chen = 4'b1110;
      @(posedge clk);
      #1 load(0, 32'hC0C0_C0C0, 1'b1);
      repeat (3) begin
         @(posedge clk);
         check("mask_no_read", 64'(rd_m[0]), 64'd0);
      end
      #1 chen = '1;
      @(posedge clk);
      check("mask_read", 64'(rd_m), 64'h1);
      wait_drain(20, "mask_drain");

      // Reset one edge after a read: the word is discarded.
      @(posedge clk);
      #1 load(2, 32'hD2D2_D2D2, 1'b0);
      wait_rd(4'b0100, 10, "mrst_read");
      #1 rst = 1'b0;
      @(posedge clk);
      check("mrst_wen", 64'(wen_m), 64'd0);
      check("mrst_dout", 64'(dout_m), 64'd0);
      #1 rst = 1'b1;
      repeat (4) begin
         @(posedge clk);
         check("mrst_no_wen", 64'(wen_m), 64'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end
endmodule
`default_nettype wire
